// File: rtl/hdb3_pkg.sv
// hdb3_pkg: state encoding and default parameters for the HDB3 BER controller.
package hdb3_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRIME   = 3'd1,
    SEARCH  = 3'd2,
    MEASURE = 3'd3,
    DONE    = 3'd4,
    FAIL    = 3'd5
  } state_t;
  localparam int DLY_MAX_DEF  = 32;
  localparam int SYNC_LEN_DEF = 16;
  localparam int WIN_LEN_DEF  = 1024;
  localparam int LOS_THR_DEF  = 4;
endpackage

// File: rtl/hdb3_dly_line.sv
// hdb3_dly_line: reference delay line; tap k is din delayed by k strobes (tap 0 is din itself).
module hdb3_dly_line #(
  parameter int DLY_MAX = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       din,
  input  logic [4:0] sel,
  output logic       tap
);
  logic [DLY_MAX-2:0] sr_q;
  logic [DLY_MAX-1:0] taps;
  assign taps = {sr_q, din};
  assign tap = taps[sel];
  always_ff @(posedge clk or posedge rst)
    if (rst) sr_q <= '0;
    else if (en) sr_q <= taps[DLY_MAX-2:0];
endmodule

// File: rtl/hdb3_ber_ctrl.sv
// hdb3_ber_ctrl: loop-delay search and BER measurement FSM; HDB3_BER_INJECT_EN enables error injection.
module hdb3_ber_ctrl
  import hdb3_pkg::*;
#(
  parameter int DLY_MAX  = DLY_MAX_DEF,
  parameter int SYNC_LEN = SYNC_LEN_DEF,
  parameter int WIN_LEN  = WIN_LEN_DEF,
  parameter int LOS_THR  = LOS_THR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        bit_en,
  input  logic        tx_bit,
  input  logic        rx_bit,
  input  logic        inj,
  output logic        gen_ena,
  output logic [2:0]  state,
  output logic [4:0]  dly_sel,
  output logic [15:0] err_cnt,
  output logic [15:0] bit_cnt,
  output logic        locked,
  output logic        done,
  output logic        fail
);
  localparam int CW = $clog2(DLY_MAX > SYNC_LEN ? DLY_MAX : SYNC_LEN) + 1;
  localparam int BW = $clog2(LOS_THR + 1);
  state_t          state_q;
  logic [4:0]      dly_q;
  logic [15:0]     err_q, bit_q, err_d;
  logic [CW-1:0]   cnt_q;
  logic [BW-1:0]   blk_q, blk_d;
  logic            ref_raw, ref_bit, mis, los, win;
  hdb3_dly_line #(.DLY_MAX(DLY_MAX)) u_dly (
    .clk(clk), .rst(rst), .en(bit_en), .din(tx_bit), .sel(dly_q), .tap(ref_raw)
  );
`ifdef HDB3_BER_INJECT_EN
  logic arm_q;
  assign ref_bit = ref_raw ^ (arm_q && state_q == MEASURE);
  always_ff @(posedge clk or posedge rst)
    if (rst) arm_q <= 1'b0;
    else arm_q <= arm_q ? !(state_q == MEASURE && bit_en) : inj;
`else
  logic unused_inj;
  assign unused_inj = inj;
  assign ref_bit = ref_raw;
`endif
  always_comb begin
    mis   = rx_bit ^ ref_bit;
    blk_d = blk_q + BW'(mis);
    los   = blk_d >= BW'(LOS_THR);
    win   = bit_q + 16'd1 == 16'(WIN_LEN);
    err_d = (mis && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      dly_q   <= '0;
      err_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
    end else if (start && (state_q == IDLE || state_q == DONE || state_q == FAIL)) begin
      state_q <= PRIME;
      dly_q   <= '0;
      err_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
    end else if (bit_en) begin
      case (state_q)
        PRIME:
          if (cnt_q == CW'(DLY_MAX - 1)) begin
            state_q <= SEARCH;
            cnt_q   <= '0;
            dly_q   <= '0;
          end else cnt_q <= cnt_q + 1'b1;
        SEARCH:
          if (mis) begin
            cnt_q <= '0;
            if (dly_q == 5'(DLY_MAX - 1)) state_q <= FAIL;
            else dly_q <= dly_q + 5'd1;
          end else if (cnt_q == CW'(SYNC_LEN - 1)) begin
            state_q <= MEASURE;
            cnt_q   <= '0;
            blk_q   <= '0;
          end else cnt_q <= cnt_q + 1'b1;
        MEASURE: begin
          bit_q <= bit_q + 16'd1;
          err_q <= err_d;
          // block counter restarts at every 16-bit boundary of bit_cnt
          blk_q <= (los || bit_q[3:0] == 4'hF) ? '0 : blk_d;
          if (win) state_q <= DONE;
          else if (los) begin
            state_q <= SEARCH;
            dly_q   <= '0;
            cnt_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  assign state   = state_q;
  assign dly_sel = dly_q;
  assign err_cnt = err_q;
  assign bit_cnt = bit_q;
  assign gen_ena = state_q == PRIME || state_q == SEARCH || state_q == MEASURE;
  assign locked  = state_q == MEASURE;
  assign done    = state_q == DONE;
  assign fail    = state_q == FAIL;
endmodule
